rcs_32bit: RTL and testbench
============================

# rcs_32bit

Registered 32-bit ripple-carry subtractor built from a chain of 1-bit full-subtractor cells. Computes `sum = a - b` (modulo 2^WIDTH) and a borrow-out flag on the `carry` port. Sits in the arithmetic/logic datapath as a standalone subtract stage with one-cycle latency.

## Interface
- One clock; reset is asynchronous and active-low.
- Parameters:
  - `WIDTH`, default 32: operand and result width in bits; legal values are ≥ 1.
- Ports:
  - `clk`, input, 1: rising-edge clock.
  - `rst_n`, input, 1: asynchronous active-low reset.
  - `in_valid`, input, 1: operands on `a`/`b` are valid this cycle.
  - `a`, input, WIDTH: minuend, unsigned.
  - `b`, input, WIDTH: subtrahend, unsigned.
  - `sum`, output, WIDTH: registered difference `a - b` mod 2^WIDTH. The port is named `sum` for compatibility with the adder family.
  - `carry`, output, 1: registered borrow-out; 1 iff `a < b` (unsigned).
  - `out_valid`, output, 1: `sum`/`carry` hold a result captured from an `in_valid` cycle.

## Operation
- Combinational core is a ripple chain of WIDTH full-subtractor cells. Bit 0 borrow-in is 0.
- Cell i computes:
  - `d[i] = a[i] ^ b[i] ^ bin[i]`
  - `bout[i] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bin[i])`
  - `bin[i+1] = bout[i]`
- `carry` is `bout[WIDTH-1]` (borrow, not adder-style carry). Do not implement the subtract as `a + ~b + 1`, which inverts the flag sense.
- Arithmetic is unsigned and wraps. Examples: `0 - 1` gives `sum = 0xFFFF_FFFF` with `carry = 1`; `a == b` gives `sum = 0` with `carry = 0`.
- No overflow or signed flag is produced.

## Timing
- Reset (`rst_n` low, asynchronous): `sum = 0`, `carry = 0`, `out_valid = 0` immediately. These values hold while `rst_n` is low.
- At each rising `clk` edge with `rst_n` high:
  - If `in_valid = 1`: `sum` and `carry` load the combinational result of the current `a`/`b`.
  - If `in_valid = 0`: `sum` and `carry` hold their previous values.
  - `out_valid` loads `in_valid` on every edge.
- Latency is exactly 1 cycle; throughput is one operation per cycle. Back-to-back `in_valid` cycles are fully pipelined, with no stall or backpressure.
- Reset asserted mid-stream discards the in-flight result. The first edge after reset deassertion behaves like any other edge.
- Changes to `a`/`b` between edges have no effect on the outputs.
- The ripple path (WIDTH cells) must close within one clock period. There is no internal pipelining.

## Structure
- Shared package `arith_pkg` holds:
  - `localparam RCS_DEFAULT_WIDTH = 32`.
  - A function or constant for the reset value of the result, which is all zeros.
- Sub-module `full_subtractor`: 1-bit cell with inputs `a`, `b`, `bin` and outputs `d`, `bout`.
- `rcs_32bit` instantiates WIDTH `full_subtractor` cells via a generate loop and adds the output registers.

## Test plan
- Reset: hold `rst_n = 0` with `a = 5`, `b = 3`, `in_valid = 1` -> `sum = 0`, `carry = 0`, `out_valid = 0`. Release reset, then one edge -> `sum = 2`, `carry = 0`, `out_valid = 1`.
- Borrow and wrap: `a = 0`, `b = 1` -> `sum = 0xFFFF_FFFF`, `carry = 1`. `a = 0`, `b = 0xFFFF_FFFF` -> `sum = 1`, `carry = 1`.
- Extremes and equality:
  - `a = 0xFFFF_FFFF`, `b = 0` -> `sum = 0xFFFF_FFFF`, `carry = 0`.
  - `a = b = 0x8000_0000` -> `sum = 0`, `carry = 0`.
- Full ripple: `a = 0x8000_0000`, `b = 1` -> `sum = 0x7FFF_FFFF`, `carry = 0`. The borrow must propagate through all 31 lower cells.
- Hold and pipeline:
  - Back-to-back valid ops `(10, 3)`, `(3, 10)` -> results `7`/`0` then `0xFFFF_FFF9`/`1` on consecutive cycles.
  - Then `in_valid = 0` with new operands -> outputs unchanged and `out_valid = 0`.
- Random: at least 10k random `a`/`b` pairs compared against a reference model of `{carry, sum} = {a < b, a - b}`. Include `WIDTH = 8` with an exhaustive 65,536-pair sweep.

Source files
------------

// File: rtl/arith_pkg.sv
// -----------------------------------------------------------------------------
// arith_pkg
//   Shared constants for the arithmetic datapath family (adders/subtractors).
//
//   RCS_DEFAULT_WIDTH   : default operand/result width of rcs_32bit.
//   RCS_RESULT_RST_BIT  : reset value of a single result bit. Replicate it to
//                         any width, e.g. {WIDTH{RCS_RESULT_RST_BIT}}.
//   RCS_BORROW_RST      : reset value of the registered borrow flag.
//   RCS_BORROW_IN       : borrow-in fed to the least significant cell.
// -----------------------------------------------------------------------------
package arith_pkg;

  localparam int RCS_DEFAULT_WIDTH = 32;

  // The result resets to all zeros. It is stored as a single bit so that it
  // can be replicated to whatever WIDTH a given instance uses.
  localparam logic RCS_RESULT_RST_BIT = 1'b0;
  localparam logic RCS_BORROW_RST     = 1'b0;

  // A plain subtract (no borrow chained in from a lower word).
  localparam logic RCS_BORROW_IN      = 1'b0;

endpackage : arith_pkg

// File: rtl/full_subtractor.sv
// -----------------------------------------------------------------------------
// full_subtractor
//   1-bit full-subtractor cell. Computes a - b - bin for one bit position.
//
//   Ports:
//     a    : minuend bit
//     b    : subtrahend bit
//     bin  : borrow in from the next less significant cell
//     d    : difference bit
//     bout : borrow out to the next more significant cell
// -----------------------------------------------------------------------------
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic a_xor_b;

  assign a_xor_b = a ^ b;
  assign d       = a_xor_b ^ bin;

  // Borrow when the subtrahend bit exceeds the minuend bit, or when the two
  // bits are equal and a borrow is already pending from below.
  assign bout = (~a & b) | (~a_xor_b & bin);

endmodule : full_subtractor

// File: rtl/rcs_32bit.sv
// -----------------------------------------------------------------------------
// rcs_32bit
//   Registered ripple-carry subtractor: sum = a - b (mod 2^WIDTH), with the
//   borrow-out reported on 'carry' (1 iff a < b, unsigned). One cycle latency,
//   one operation per cycle, no backpressure.
//
//   Parameters:
//     WIDTH     : operand/result width in bits (>= 1)
//
//   Ports:
//     clk       : rising-edge clock
//     rst_n     : asynchronous active-low reset
//     in_valid  : a/b are valid this cycle; result registers load only then
//     a         : minuend (unsigned)
//     b         : subtrahend (unsigned)
//     sum       : registered difference (name shared with the adder family)
//     carry     : registered borrow-out (borrow sense, not adder carry)
//     out_valid : sum/carry were captured from an in_valid cycle
// -----------------------------------------------------------------------------
module rcs_32bit
  import arith_pkg::*;
#(
  parameter int WIDTH = RCS_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             out_valid
);

  localparam logic [WIDTH-1:0] SUM_RST = {WIDTH{RCS_RESULT_RST_BIT}};

  // ---------------------------------------------------------------------------
  // Ripple chain. borrow_chain[i] is the borrow into cell i; the top entry is
  // the borrow out of the most significant cell.
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   borrow_chain;
  logic [WIDTH-1:0] diff;

  assign borrow_chain[0] = RCS_BORROW_IN;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      full_subtractor u_fs (
        .a    (a[gi]),
        .b    (b[gi]),
        .bin  (borrow_chain[gi]),
        .d    (diff[gi]),
        .bout (borrow_chain[gi+1])
      );
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Output registers. The result holds across idle cycles; out_valid follows
  // in_valid every cycle so it marks only freshly captured results.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] sum_d, sum_q;
  logic             carry_d, carry_q;
  logic             out_valid_d, out_valid_q;

  always_comb begin
    sum_d       = sum_q;
    carry_d     = carry_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      sum_d   = diff;
      carry_d = borrow_chain[WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= SUM_RST;
      carry_q     <= RCS_BORROW_RST;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign sum       = sum_q;
  assign carry     = carry_q;
  assign out_valid = out_valid_q;

endmodule : rcs_32bit

// File: tb/tb_rcs_32bit.sv
module tb_rcs_32bit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] a, b, sum;
  logic        carry, out_valid;

  logic        in_valid8;
  logic [7:0]  a8, b8, sum8;
  logic        carry8, out_valid8;

  int checks;
  int failures;

  rcs_32bit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .sum       (sum),
    .carry     (carry),
    .out_valid (out_valid)
  );

  rcs_32bit #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid8),
    .a         (a8),
    .b         (b8),
    .sum       (sum8),
    .carry     (carry8),
    .out_valid (out_valid8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; a = 32'd5; b = 32'd3;
    in_valid8 = 1'b0; a8 = 8'd0; b8 = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sum !== 32'd0 || carry !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold sum=%h carry=%b ov=%b expected sum=0 carry=0 ov=0", sum, carry, out_valid);
    end
    checks++;
    if (sum8 !== 8'd0 || carry8 !== 1'b0 || out_valid8 !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold_w8 sum=%h carry=%b ov=%b expected sum=0 carry=0 ov=0", sum8, carry8, out_valid8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (sum !== 32'd2 || carry !== 1'b0 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_release sum=%h carry=%b ov=%b expected sum=2 carry=0 ov=1", sum, carry, out_valid);
    end
    $display("reset: 5-3 -> sum=%h carry=%b ov=%b", sum, carry, out_valid);
  endtask

  task automatic test_borrow_wrap();
    a = 32'd0; b = 32'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (sum !== 32'hFFFF_FFFF || carry !== 1'b1 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL wrap_0m1 sum=%h carry=%b ov=%b expected sum=ffffffff carry=1 ov=1", sum, carry, out_valid);
    end
    $display("borrow: 0-1 -> sum=%h carry=%b", sum, carry);
    a = 32'd0; b = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    checks++;
    if (sum !== 32'd1 || carry !== 1'b1) begin
      failures++;
      $display("FAIL wrap_0mmax sum=%h carry=%b expected sum=00000001 carry=1", sum, carry);
    end
    $display("borrow: 0-ffffffff -> sum=%h carry=%b", sum, carry);
  endtask

  task automatic test_extremes();
    a = 32'hFFFF_FFFF; b = 32'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (sum !== 32'hFFFF_FFFF || carry !== 1'b0) begin
      failures++;
      $display("FAIL max_m0 sum=%h carry=%b expected sum=ffffffff carry=0", sum, carry);
    end
    $display("extreme: ffffffff-0 -> sum=%h carry=%b", sum, carry);
    a = 32'h8000_0000; b = 32'h8000_0000;
    @(posedge clk); #1;
    checks++;
    if (sum !== 32'd0 || carry !== 1'b0) begin
      failures++;
      $display("FAIL equal sum=%h carry=%b expected sum=00000000 carry=0", sum, carry);
    end
    $display("extreme: 80000000-80000000 -> sum=%h carry=%b", sum, carry);
  endtask

  task automatic test_full_ripple();
    a = 32'h8000_0000; b = 32'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (sum !== 32'h7FFF_FFFF || carry !== 1'b0) begin
      failures++;
      $display("FAIL full_ripple sum=%h carry=%b expected sum=7fffffff carry=0", sum, carry);
    end
    $display("ripple: 80000000-1 -> sum=%h carry=%b", sum, carry);
  endtask

  task automatic test_back_to_back();
    a = 32'd10; b = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 32'd3; b = 32'd10;
    checks++;
    if (sum !== 32'd7 || carry !== 1'b0 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first sum=%h carry=%b ov=%b expected sum=00000007 carry=0 ov=1", sum, carry, out_valid);
    end
    $display("b2b: 10-3 -> sum=%h carry=%b", sum, carry);
    @(posedge clk); #1;
    checks++;
    if (sum !== 32'hFFFF_FFF9 || carry !== 1'b1 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL b2b_second sum=%h carry=%b ov=%b expected sum=fffffff9 carry=1 ov=1", sum, carry, out_valid);
    end
    $display("b2b: 3-10 -> sum=%h carry=%b", sum, carry);
  endtask

  task automatic test_hold();
    a = 32'd100; b = 32'd1; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (sum !== 32'hFFFF_FFF9 || carry !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL hold sum=%h carry=%b ov=%b expected sum=fffffff9 carry=1 ov=0", sum, carry, out_valid);
    end
    $display("hold: idle 100-1 -> sum=%h carry=%b ov=%b", sum, carry, out_valid);
  endtask

  task automatic test_async_reset();
    a = 32'd50; b = 32'd20; in_valid = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (sum !== 32'd30 || carry !== 1'b0) begin
      failures++;
      $display("FAIL pre_reset sum=%h carry=%b expected sum=0000001e carry=0", sum, carry);
    end
    a = 32'd9; b = 32'd4;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (sum !== 32'd0 || carry !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL async_reset sum=%h carry=%b ov=%b expected sum=0 carry=0 ov=0", sum, carry, out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (sum !== 32'd0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_discard sum=%h ov=%b expected sum=0 ov=0", sum, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (sum !== 32'd0 || carry !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle sum=%h carry=%b ov=%b expected sum=0 carry=0 ov=0", sum, carry, out_valid);
    end
    $display("async reset mid-stream: sum=%h carry=%b ov=%b", sum, carry, out_valid);
  endtask

  // Random 32-bit operands (with idle cycles mixed in) alongside an exhaustive
  // 8-bit sweep on the second instance; both checked every cycle.
  task automatic test_random_sweep();
    logic [31:0] exp_sum;
    logic        exp_c;
    logic [7:0]  exp_sum8;
    logic        exp_c8;
    int          fail_before;
    int          valid_ops;
    fail_before = failures;
    valid_ops   = 0;
    exp_sum     = sum;
    exp_c       = carry;
    for (int i = 0; i < 65536; i++) begin
      a = $urandom;
      b = $urandom;
      if ((i % 97) == 0) b = a;
      if ((i % 101) == 0) a = 32'd0;
      in_valid = ($urandom_range(3) != 0);
      a8 = i[15:8];
      b8 = i[7:0];
      in_valid8 = 1'b1;
      if (in_valid) begin
        exp_sum = a - b;
        exp_c   = (a < b);
        valid_ops++;
      end
      exp_sum8 = a8 - b8;
      exp_c8   = (a8 < b8);
      @(posedge clk); #1;
      checks++;
      if (sum !== exp_sum || carry !== exp_c || out_valid !== in_valid) begin
        failures++;
        if (failures - fail_before <= 10)
          $display("FAIL rand32 i=%0d sum=%h carry=%b ov=%b expected sum=%h carry=%b ov=%b",
                   i, sum, carry, out_valid, exp_sum, exp_c, in_valid);
      end
      checks++;
      if (sum8 !== exp_sum8 || carry8 !== exp_c8 || out_valid8 !== 1'b1) begin
        failures++;
        if (failures - fail_before <= 10)
          $display("FAIL sweep8 a=%h b=%h sum=%h carry=%b ov=%b expected sum=%h carry=%b ov=1",
                   a8, b8, sum8, carry8, out_valid8, exp_sum8, exp_c8);
      end
    end
    in_valid = 1'b0; in_valid8 = 1'b0;
    $display("random/sweep: %0d valid 32-bit ops, 65536 8-bit pairs, %0d errors",
             valid_ops, failures - fail_before);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_borrow_wrap();
    test_extremes();
    test_full_ripple();
    test_back_to_back();
    test_hold();
    test_async_reset();
    test_random_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_rcs_32bit
